// File: rtl/step_controller.sv
// Single-step / run controller: synchronizes the divided clock and two bouncy buttons,
// and gates one-cycle CPU advance strobes from a PAUSE/STEP/RUN/HALTED state machine.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             clkin,
    input  logic             clr_n,
    input  logic             slow_clk,
    input  logic             btn_step,
    input  logic             btn_mode,
    input  logic             halt,
    output logic             cpu_en,
    output logic             run_mode,
    output logic             halted,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       fsm_state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        PAUSE  = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0] clk_sync;
    logic [1:0] step_sync;
    logic [1:0] mode_sync;
    logic       clk_d;
    logic       tick;

    logic [1:0]      raw_lvl;
    logic [1:0]      deb;
    logic [1:0]      deb_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic            step_press;
    logic            mode_press;

    logic cpu_en_next;

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            clk_sync  <= '0;
            step_sync <= '0;
            mode_sync <= '0;
            clk_d     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], slow_clk};
            step_sync <= {step_sync[0], btn_step};
            mode_sync <= {mode_sync[0], btn_mode};
            clk_d     <= clk_sync[1];
        end
    end

    assign tick    = clk_sync[1] & ~clk_d;
    assign raw_lvl = {mode_sync[1], step_sync[1]};

    // Bit 0 is the step button, bit 1 the mode button.
    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (raw_lvl[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press      = deb & ~deb_d;
    assign step_press = press[0];
    assign mode_press = press[1];

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            state <= PAUSE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PAUSE: begin
                if (mode_press)      state_next = RUN;
                else if (step_press) state_next = STEP;
            end
            STEP: begin
                if (halt)      state_next = HALTED;
                else if (tick) state_next = PAUSE;
            end
            RUN: begin
                if (halt)            state_next = HALTED;
                else if (mode_press) state_next = PAUSE;
            end
            HALTED: begin
                if (mode_press && !halt) state_next = PAUSE;
            end
            default: state_next = PAUSE;
        endcase
    end

    // Halt outranks a coincident tick, so the strobe is suppressed that cycle.
    always_comb begin
        cpu_en_next = 1'b0;
        run_mode    = 1'b0;
        halted      = 1'b0;
        if ((state == STEP || state == RUN) && tick && !halt) cpu_en_next = 1'b1;
        if (state == RUN)    run_mode = 1'b1;
        if (state == HALTED) halted   = 1'b1;
    end

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            cpu_en <= cpu_en_next;
            if (cpu_en_next && !(&step_count)) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed button/slow_clk sequences, expected cpu_en pulses
// queued with their cycle and count, a negedge monitor pops and compares them.
module tb_step_controller;

    logic        clk;
    logic        clr_n;
    logic        slow_clk;
    logic        btn_step;
    logic        btn_mode;
    logic        halt;
    logic        cpu_en;
    logic        run_mode;
    logic        halted;
    logic [15:0] step_count;
    logic [1:0]  fsm_state;

    logic        sat_slow;
    logic        sat_mode;
    logic        sat_cpu_en;
    logic        sat_run_mode;
    logic        sat_halted;
    logic [7:0]  sat_count;
    logic [1:0]  sat_state;

    int          checks;
    int          errors;
    int          cyc;
    int          sat_pulses;
    logic [15:0] model_count;
    logic        cpu_en_prev;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];

    step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clkin(clk), .clr_n(clr_n), .slow_clk(slow_clk), .btn_step(btn_step),
        .btn_mode(btn_mode), .halt(halt), .cpu_en(cpu_en), .run_mode(run_mode),
        .halted(halted), .step_count(step_count), .fsm_state(fsm_state)
    );

    step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) sat_dut (
        .clkin(clk), .clr_n(clr_n), .slow_clk(sat_slow), .btn_step(1'b0),
        .btn_mode(sat_mode), .halt(1'b0), .cpu_en(sat_cpu_en), .run_mode(sat_run_mode),
        .halted(sat_halted), .step_count(sat_count), .fsm_state(sat_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input bit do_mode, input bit do_step, input int hold);
        btn_mode = do_mode;
        btn_step = do_step;
        cycles(hold);
        btn_mode = 1'b0;
        btn_step = 1'b0;
        cycles(10);
    endtask

    // Raise slow_clk just after an edge; a strobe is expected three edges later.
    task automatic slow_edge(input bit expect_pulse);
        slow_clk = 1'b1;
        if (expect_pulse) begin
            if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
            exp_q.push_back(model_count);
            exp_cyc_q.push_back(cyc + 3);
        end
        cycles(3);
        slow_clk = 1'b0;
        cycles(3);
    endtask

    // scoreboard monitor
    initial cpu_en_prev = 1'b0;
    always @(negedge clk) begin
        if (cpu_en) begin
            if (cpu_en_prev) check("cpu_en_back_to_back", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_cpu_en", {16'd0, step_count}, 32'hFFFF_FFFF);
            end else begin
                check("pulse_count", {16'd0, step_count}, {16'd0, exp_q.pop_front()});
                check("pulse_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        cpu_en_prev = cpu_en;
    end

    initial sat_pulses = 0;
    always @(negedge clk) if (sat_cpu_en) sat_pulses++;

    initial begin
        checks      = 0;
        errors      = 0;
        model_count = '0;
        clr_n       = 1'b0;
        slow_clk    = 1'b0;
        btn_step    = 1'b0;
        btn_mode    = 1'b0;
        halt        = 1'b0;
        sat_slow    = 1'b0;
        sat_mode    = 1'b0;

        cycles(3);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_run_mode", {31'd0, run_mode}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_step_count", {16'd0, step_count}, 32'd0);
        check("reset_state", {30'd0, fsm_state}, 32'd0);
        clr_n = 1'b1;
        cycles(2);

        // single step: one pulse only, back to PAUSE
        press_btn(1'b0, 1'b1, 10);
        check("step_state", {30'd0, fsm_state}, 32'd1);
        slow_edge(1'b1);
        slow_edge(1'b0);
        slow_edge(1'b0);
        check("step_done_state", {30'd0, fsm_state}, 32'd0);
        check("step_done_run", {31'd0, run_mode}, 32'd0);
        check("step_done_count", {16'd0, step_count}, 32'd1);

        // mode glitch too short to pass the debouncer
        btn_mode = 1'b1;
        cycles(3);
        btn_mode = 1'b0;
        cycles(10);
        check("glitch_state", {30'd0, fsm_state}, 32'd0);

        // run mode, five ticks
        press_btn(1'b1, 1'b0, 8);
        check("run_entered", {31'd0, run_mode}, 32'd1);
        for (int i = 0; i < 5; i++) slow_edge(1'b1);
        check("run_count", {16'd0, step_count}, 32'd6);

        // mode press on the same cycle as a tick: pulse issued, then PAUSE
        btn_mode = 1'b1;
        cycles(4);
        slow_clk = 1'b1;
        model_count = model_count + 16'd1;
        exp_q.push_back(model_count);
        exp_cyc_q.push_back(cyc + 3);
        cycles(4);
        btn_mode = 1'b0;
        slow_clk = 1'b0;
        cycles(10);
        check("coincident_pause", {30'd0, fsm_state}, 32'd0);
        check("coincident_count", {16'd0, step_count}, 32'd7);

        // both buttons together: mode wins
        press_btn(1'b1, 1'b1, 8);
        check("both_run", {30'd0, fsm_state}, 32'd2);

        // halt coincident with tick
        slow_clk = 1'b1;
        cycles(2);
        halt = 1'b1;
        cycles(1);
        check("halt_entered", {31'd0, halted}, 32'd1);
        slow_clk = 1'b0;
        cycles(3);
        press_btn(1'b1, 1'b0, 8);
        check("halt_mode_ignored", {31'd0, halted}, 32'd1);
        slow_edge(1'b0);
        halt = 1'b0;
        cycles(1);
        press_btn(1'b1, 1'b0, 8);
        check("halt_exit_halted", {31'd0, halted}, 32'd0);
        check("halt_exit_state", {30'd0, fsm_state}, 32'd0);
        check("halt_count", {16'd0, step_count}, 32'd7);

        // step presses ignored in RUN
        press_btn(1'b1, 1'b0, 8);
        press_btn(1'b0, 1'b1, 8);
        check("run_ignores_step", {30'd0, fsm_state}, 32'd2);

        // async reset with a tick in the synchronizer
        slow_clk = 1'b1;
        cycles(1);
        #2 clr_n = 1'b0;
        #1;
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_run_mode", {31'd0, run_mode}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count", {16'd0, step_count}, 32'd0);
        model_count = '0;
        cycles(2);
        #3 clr_n = 1'b1;
        cycles(6);
        slow_clk = 1'b0;
        cycles(3);
        check("post_rst_state", {30'd0, fsm_state}, 32'd0);
        check("post_rst_count", {16'd0, step_count}, 32'd0);

        // saturation on the 8-bit instance
        sat_mode = 1'b1;
        cycles(8);
        sat_mode = 1'b0;
        cycles(10);
        for (int i = 0; i < 250; i++) begin
            sat_slow = 1'b1;
            cycles(2);
            sat_slow = 1'b0;
            cycles(2);
        end
        cycles(4);
        check("sat_partial", {24'd0, sat_count}, 32'd250);
        for (int i = 0; i < 10; i++) begin
            sat_slow = 1'b1;
            cycles(2);
            sat_slow = 1'b0;
            cycles(2);
        end
        cycles(4);
        check("sat_full", {24'd0, sat_count}, 32'hFF);
        check("sat_pulses", sat_pulses, 32'd260);
        check("sat_run_mode", {31'd0, sat_run_mode}, 32'd1);
        check("sat_halted", {31'd0, sat_halted}, 32'd0);
        check("sat_state", {30'd0, sat_state}, 32'd2);

        cycles(5);
        check("pending_pulses", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
